// File: rtl/load_pkg.sv
// ---------------------------------------------------------------------------
// load_pkg
// Shared definitions for the load-align datapath:
//   - SZ_B/SZ_H/SZ_W/SZ_D : access-size encodings carried on req_size
//   - load_state_t        : load_align_unit FSM states
//   - xlen_is_legal()     : datapath widths the unit supports (32 or 64)
//   - size_is_legal()     : a doubleword access exists only on a 64-bit datapath
// ---------------------------------------------------------------------------
package load_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } load_state_t;

    function automatic bit xlen_is_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    function automatic bit size_is_legal(input int xlen, input logic [1:0] size);
        return (size != SZ_D) || (xlen == 64);
    endfunction

endpackage

// File: rtl/load_extract.sv
// ---------------------------------------------------------------------------
// load_extract
// Combinational byte-lane extractor. Shifts the two-word window {hi,lo} right
// by off bytes (little-endian), keeps the low 1/2/4/8 bytes and sign- or
// zero-extends them to XLEN.
// Ports:
//   merged      in  2*XLEN  {hi word, lo word}; hi is zero when unused
//   off         in  OFFW    byte offset of the access within lo
//   size        in  2       SZ_B/SZ_H/SZ_W/SZ_D
//   is_unsigned in  1       1 = zero-extend, 0 = sign-extend
//   result      out XLEN    extended load value
// ---------------------------------------------------------------------------
module load_extract
    import load_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OFFW = $clog2(XLEN/8)
) (
    input  logic [2*XLEN-1:0] merged,
    input  logic [OFFW-1:0]   off,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [XLEN-1:0]   result
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] field;
    logic            sign;

    // A full-width access leaves mask all-ones, so ~mask is zero and the
    // value passes through untouched whatever is_unsigned says.
    always_comb begin
        shifted = XLEN'(merged >> {off, 3'b000});
        mask    = '1;
        sign    = shifted[XLEN-1];
        case (size)
            SZ_B: begin
                mask = XLEN'(8'hFF);
                sign = shifted[7];
            end
            SZ_H: begin
                mask = XLEN'(16'hFFFF);
                sign = shifted[15];
            end
            SZ_W: begin
                mask = XLEN'(32'hFFFF_FFFF);
                sign = shifted[31];
            end
            default: ;
        endcase
        field  = shifted & mask;
        result = (!is_unsigned && sign) ? (field | ~mask) : field;
    end

endmodule

// File: rtl/load_align_unit.sv
// ---------------------------------------------------------------------------
// load_align_unit
// Load-data path between the data-memory port and writeback. Accepts one load
// at a time, issues one memory read (two for a word-crossing access when
// LOAD_MISALIGN_SPLIT_EN is defined), extracts and extends the addressed
// bytes and returns them over a valid/ready handshake.
// Build option:
//   LOAD_MISALIGN_SPLIT_EN  defined   -> misaligned loads are serviced, crossing
//                                        ones with a second read of the next word
//                           undefined -> misaligned loads return resp_err
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            load request handshake (ready only in IDLE)
//   req_off/req_size/req_unsigned  byte offset, size code, zero-extend flag
//   mem_req_valid/mem_req_ready    memory read request handshake
//   mem_req_hi                     0 = base word, 1 = next aligned word
//   mem_rvalid/mem_rdata           memory read return
//   resp_valid/resp_ready          result handshake
//   resp_data/resp_err             extended result, misaligned/illegal flag
// ---------------------------------------------------------------------------
module load_align_unit
    import load_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OFFW = $clog2(XLEN/8)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OFFW-1:0] req_off,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_req_hi,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_err
);

    localparam int BYTES = XLEN / 8;

    if (!xlen_is_legal(XLEN)) begin : g_bad_xlen
        $error("load_align_unit: XLEN must be 32 or 64");
    end

    load_state_t     state;
    logic [OFFW-1:0] off_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [3:0]      nb;
    logic            illegal;
    logic            reject;
    logic [XLEN-1:0] ext_lo;
    logic [XLEN-1:0] ext_hi;
    logic [XLEN-1:0] ext_result;
`ifdef LOAD_MISALIGN_SPLIT_EN
    logic            crosses;
    logic            split_q;
    logic [XLEN-1:0] lo_q;
`else
    logic            misaligned;
`endif

    // Ready depends on rst as well so that it reads 0 while reset is held.
    assign req_ready = (state == ST_IDLE) && !rst;

    // Classify the incoming request: rejected requests never touch memory.
    always_comb begin
        nb      = 4'd1 << req_size;
        illegal = !size_is_legal(XLEN, req_size);
`ifdef LOAD_MISALIGN_SPLIT_EN
        crosses = (32'(req_off) + 32'(nb)) > 32'(BYTES);
        reject  = illegal;
`else
        misaligned = (OFFW'(nb - 4'd1) & req_off) != '0;
        reject     = illegal || misaligned;
`endif
    end

    // Extractor sees the live read data so the result is registered in the
    // same edge that consumes mem_rvalid; in WAIT1 the saved low word joins it.
    always_comb begin
        ext_lo = mem_rdata;
        ext_hi = '0;
`ifdef LOAD_MISALIGN_SPLIT_EN
        if (state == ST_WAIT1) begin
            ext_lo = lo_q;
            ext_hi = mem_rdata;
        end
`endif
    end

    load_extract #(
        .XLEN (XLEN),
        .OFFW (OFFW)
    ) u_extract (
        .merged      ({ext_hi, ext_lo}),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ext_result)
    );

    // Main FSM with registered outputs; mem_rvalid is only looked at in the
    // WAIT states, so stray or post-reset returns fall on the floor.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            mem_req_valid <= 1'b0;
            mem_req_hi    <= 1'b0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_err      <= 1'b0;
            off_q         <= '0;
            size_q        <= SZ_B;
            uns_q         <= 1'b0;
`ifdef LOAD_MISALIGN_SPLIT_EN
            split_q       <= 1'b0;
            lo_q          <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        off_q  <= req_off;
                        size_q <= req_size;
                        uns_q  <= req_unsigned;
`ifdef LOAD_MISALIGN_SPLIT_EN
                        split_q <= crosses;
`endif
                        if (reject) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= '0;
                            resp_err   <= 1'b1;
                        end else begin
                            state         <= ST_REQ0;
                            mem_req_valid <= 1'b1;
                            mem_req_hi    <= 1'b0;
                        end
                    end
                end
                ST_REQ0: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= ST_WAIT0;
                    end
                end
                ST_WAIT0: begin
                    if (mem_rvalid) begin
`ifdef LOAD_MISALIGN_SPLIT_EN
                        if (split_q) begin
                            lo_q          <= mem_rdata;
                            state         <= ST_REQ1;
                            mem_req_valid <= 1'b1;
                            mem_req_hi    <= 1'b1;
                        end else begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= ext_result;
                            resp_err   <= 1'b0;
                        end
`else
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= ext_result;
                        resp_err   <= 1'b0;
`endif
                    end
                end
`ifdef LOAD_MISALIGN_SPLIT_EN
                ST_REQ1: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_req_hi    <= 1'b0;
                        state         <= ST_WAIT1;
                    end
                end
                ST_WAIT1: begin
                    if (mem_rvalid) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= ext_result;
                        resp_err   <= 1'b0;
                    end
                end
`endif
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// ---------------------------------------------------------------------------
// tb_load_align_unit
// Drives a 32-bit and a 64-bit load_align_unit (sel picks the active one)
// with directed and random loads, a randomised memory responder and a
// byte-array reference model. Honours LOAD_MISALIGN_SPLIT_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic [2:0]  req_off;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        mem_req_ready;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        resp_ready;

    logic        rr32, mrv32, mrh32, rv32, re32;
    logic [31:0] rd32;
    logic        rr64, mrv64, mrh64, rv64, re64;
    logic [63:0] rd64;

    logic        req_ready_m, mem_req_valid_m, mem_req_hi_m, resp_valid_m, resp_err_m;
    logic [63:0] resp_data_m;

    int tests_run;
    int tests_failed;

    always #5 clk = ~clk;

    assign req_ready_m     = sel ? rr64  : rr32;
    assign mem_req_valid_m = sel ? mrv64 : mrv32;
    assign mem_req_hi_m    = sel ? mrh64 : mrh32;
    assign resp_valid_m    = sel ? rv64  : rv32;
    assign resp_err_m      = sel ? re64  : re32;
    assign resp_data_m     = sel ? rd64  : {32'h0, rd32};

    load_align_unit #(.XLEN(32)) dut32 (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid & ~sel),
        .req_ready     (rr32),
        .req_off       (req_off[1:0]),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .mem_req_valid (mrv32),
        .mem_req_ready (mem_req_ready & ~sel),
        .mem_req_hi    (mrh32),
        .mem_rvalid    (mem_rvalid & ~sel),
        .mem_rdata     (mem_rdata[31:0]),
        .resp_valid    (rv32),
        .resp_ready    (resp_ready & ~sel),
        .resp_data     (rd32),
        .resp_err      (re32)
    );

    load_align_unit #(.XLEN(64)) dut64 (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid & sel),
        .req_ready     (rr64),
        .req_off       (req_off),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .mem_req_valid (mrv64),
        .mem_req_ready (mem_req_ready & sel),
        .mem_req_hi    (mrh64),
        .mem_rvalid    (mem_rvalid & sel),
        .mem_rdata     (mem_rdata),
        .resp_valid    (rv64),
        .resp_ready    (resp_ready & sel),
        .resp_data     (rd64),
        .resp_err      (re64)
    );

    // Reference: treat {hi,lo} as a little-endian byte array, gather nb bytes
    // from off, then extend from the top gathered bit up to xlen.
    function automatic void ref_load(input int xlen, input int off, input int size, input bit uns,
                                     input logic [63:0] lo, input logic [63:0] hi,
                                     output logic [63:0] data, output logic err, output int nreads);
        int          nb;
        int          wb;
        logic [7:0]  bytes [16];
        logic [63:0] val;
        nb     = 1 << size;
        wb     = xlen / 8;
        data   = '0;
        err    = 1'b0;
        nreads = 0;
        if (size == 3 && xlen == 32) begin
            err = 1'b1;
            return;
        end
        if ((off % nb) != 0) begin
`ifndef LOAD_MISALIGN_SPLIT_EN
            err = 1'b1;
            return;
`endif
        end
        nreads = (off + nb > wb) ? 2 : 1;
        for (int i = 0; i < wb; i++) begin
            bytes[i]      = lo[8*i +: 8];
            bytes[wb + i] = hi[8*i +: 8];
        end
        val = '0;
        for (int i = 0; i < nb; i++) val[8*i +: 8] = bytes[off + i];
        if (!uns && val[8*nb - 1]) begin
            for (int b = 8*nb; b < xlen; b++) val[b] = 1'b1;
        end
        data = val;
    endfunction

    // Runs one complete load on the selected DUT acting as memory and consumer.
    task automatic run_load(input bit s, input int off, input int size, input bit uns,
                            input logic [63:0] lo, input logic [63:0] hi,
                            input bit fast, input int rdelay,
                            output logic [63:0] data, output logic err, output int nmem,
                            output logic [1:0] hiseq, output int lat, output bit unstable,
                            output bit after_ok, output bit timeout);
        int          cyc;
        int          held;
        int          cnt;
        bit          pending;
        bit          finishing;
        bit          done;
        logic [63:0] pdata;
        data = '0; err = 1'b0; nmem = 0; hiseq = 2'b00; lat = -1;
        unstable = 1'b0; after_ok = 1'b0; timeout = 1'b0;
        held = 0; cnt = 0; pending = 1'b0; finishing = 1'b0; done = 1'b0; pdata = '0; cyc = 0;
        sel = s;
        #1;
        while (!req_ready_m && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!req_ready_m) begin
            timeout = 1'b1;
        end else begin
            req_valid    = 1'b1;
            req_off      = 3'(off);
            req_size     = 2'(size);
            req_unsigned = uns;
            resp_ready   = (rdelay < 0);
            @(negedge clk);
            req_valid = 1'b0;
            cyc = 1;
            while (!done && cyc < 300) begin
                mem_rvalid    = 1'b0;
                mem_req_ready = 1'b0;
                mem_rdata     = {$urandom, $urandom};
                if (pending) begin
                    if (cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = pdata;
                        pending    = 1'b0;
                    end else begin
                        cnt--;
                    end
                end else if (!fast && $urandom_range(0, 3) == 0) begin
                    mem_rvalid = 1'b1;
                end
                if (mem_req_valid_m && (fast || $urandom_range(0, 1) == 1)) begin
                    mem_req_ready = 1'b1;
                    nmem++;
                    if (nmem <= 2) hiseq[nmem-1] = mem_req_hi_m;
                    pdata   = mem_req_hi_m ? hi : lo;
                    pending = 1'b1;
                    cnt     = fast ? 0 : int'($urandom_range(0, 2));
                end
                if (resp_valid_m) begin
                    if (held == 0) begin
                        data = resp_data_m;
                        err  = resp_err_m;
                        lat  = cyc;
                    end else if (resp_data_m !== data || resp_err_m !== err) begin
                        unstable = 1'b1;
                    end
                    held++;
                    if (rdelay < 0 || held > rdelay) resp_ready = 1'b1;
                    finishing = resp_ready;
                end
                @(negedge clk);
                cyc++;
                if (finishing) done = 1'b1;
            end
            timeout  = !done;
            after_ok = !resp_valid_m && req_ready_m;
        end
        req_valid     = 1'b0;
        mem_rvalid    = 1'b0;
        mem_req_ready = 1'b0;
        resp_ready    = 1'b0;
        if (timeout) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({rr32, mrv32, mrh32, rv32, re32, rr64, mrv64, mrh64, rv64, re64} !== 10'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctl: got %b expected %b",
                     {rr32, mrv32, mrh32, rv32, re32, rr64, mrv64, mrh64, rv64, re64}, 10'b0);
        end
        tests_run++;
        if ({rd32, rd64} !== 96'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got %h expected 0", {rd32, rd64});
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if ({rr32, rr64, mrv32, mrv64, rv32, rv64} !== 6'b110000) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: got %b expected %b",
                     {rr32, rr64, mrv32, mrv64, rv32, rv64}, 6'b110000);
        end
        @(negedge clk);
    endtask

    typedef struct {
        bit          s;
        int          off;
        int          size;
        bit          uns;
        logic [63:0] lo;
        logic [63:0] exp_data;
        bit          exp_err;
        int          exp_lat;
        int          exp_nmem;
    } vec_t;

    task automatic test_directed();
        vec_t        v [8];
        logic [63:0] data;
        logic        err;
        int          nmem, lat;
        logic [1:0]  hiseq;
        bit          unstable, after_ok, timeout;
        v[0] = '{1'b0, 3, 0, 1'b0, 64'h80FF1234, 64'hFFFFFF80, 1'b0, 3, 1};
        v[1] = '{1'b0, 3, 0, 1'b1, 64'h80FF1234, 64'h00000080, 1'b0, 3, 1};
        v[2] = '{1'b0, 2, 1, 1'b0, 64'h80015678, 64'hFFFF8001, 1'b0, 3, 1};
        v[3] = '{1'b0, 2, 1, 1'b1, 64'h80015678, 64'h00008001, 1'b0, 3, 1};
        v[4] = '{1'b0, 0, 2, 1'b0, 64'hDEADBEEF, 64'hDEADBEEF, 1'b0, 3, 1};
        v[5] = '{1'b1, 0, 3, 1'b0, 64'h8000000000000001, 64'h8000000000000001, 1'b0, 3, 1};
        v[6] = '{1'b1, 4, 2, 1'b0, 64'h8000000000000000, 64'hFFFFFFFF80000000, 1'b0, 3, 1};
        v[7] = '{1'b0, 0, 3, 1'b0, 64'h12345678, 64'h0, 1'b1, 1, 0};
        for (int i = 0; i < 8; i++) begin
            run_load(v[i].s, v[i].off, v[i].size, v[i].uns, v[i].lo, 64'h0, 1'b1, 0,
                     data, err, nmem, hiseq, lat, unstable, after_ok, timeout);
            tests_run++;
            if (timeout !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL directed[%0d] timeout: got %0d expected 0", i, timeout);
            end
            tests_run++;
            if (data !== v[i].exp_data) begin
                tests_failed++;
                $display("[TB] FAIL directed[%0d] data: got %h expected %h", i, data, v[i].exp_data);
            end
            tests_run++;
            if (err !== v[i].exp_err) begin
                tests_failed++;
                $display("[TB] FAIL directed[%0d] err: got %0d expected %0d", i, err, v[i].exp_err);
            end
            tests_run++;
            if (lat !== v[i].exp_lat) begin
                tests_failed++;
                $display("[TB] FAIL directed[%0d] latency: got %0d expected %0d", i, lat, v[i].exp_lat);
            end
            tests_run++;
            if (nmem !== v[i].exp_nmem) begin
                tests_failed++;
                $display("[TB] FAIL directed[%0d] mem_reqs: got %0d expected %0d", i, nmem, v[i].exp_nmem);
            end
        end
    endtask

    task automatic test_split();
        logic [63:0] data, exp_data;
        logic        err, exp_err;
        int          nmem, lat, exp_nmem, exp_lat;
        logic [1:0]  hiseq, exp_hiseq;
        bit          unstable, after_ok, timeout;
`ifdef LOAD_MISALIGN_SPLIT_EN
        exp_data = 64'h55443322; exp_err = 1'b0; exp_nmem = 2; exp_lat = 5; exp_hiseq = 2'b10;
`else
        exp_data = 64'h0; exp_err = 1'b1; exp_nmem = 0; exp_lat = 1; exp_hiseq = 2'b00;
`endif
        run_load(1'b0, 1, 2, 1'b0, 64'h44332211, 64'h88776655, 1'b1, 0,
                 data, err, nmem, hiseq, lat, unstable, after_ok, timeout);
        tests_run++;
        if (data !== exp_data || err !== exp_err) begin
            tests_failed++;
            $display("[TB] FAIL split_result: got %h/%0d expected %h/%0d", data, err, exp_data, exp_err);
        end
        tests_run++;
        if (nmem !== exp_nmem || hiseq !== exp_hiseq) begin
            tests_failed++;
            $display("[TB] FAIL split_mem_reqs: got %0d/%b expected %0d/%b", nmem, hiseq, exp_nmem, exp_hiseq);
        end
        tests_run++;
        if (lat !== exp_lat || timeout !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL split_latency: got %0d (timeout %0d) expected %0d", lat, timeout, exp_lat);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] data;
        logic        err;
        int          nmem, lat;
        logic [1:0]  hiseq;
        bit          unstable, after_ok, timeout;
        for (int k = 0; k < 2; k++) begin
            run_load(1'b0, 0, 2, 1'b0, 64'hDEADBEEF, 64'h0, 1'b1, (k == 0) ? 3 : -1,
                     data, err, nmem, hiseq, lat, unstable, after_ok, timeout);
            tests_run++;
            if (data !== 64'hDEADBEEF || err !== 1'b0 || timeout !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL backpressure[%0d] data: got %h/%0d expected deadbeef/0", k, data, err);
            end
            tests_run++;
            if (unstable !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL backpressure[%0d] hold: got unstable=%0d expected 0", k, unstable);
            end
            tests_run++;
            if (after_ok !== 1'b1 || lat !== 3) begin
                tests_failed++;
                $display("[TB] FAIL backpressure[%0d] completion: got after_ok=%0d lat=%0d expected 1/3",
                         k, after_ok, lat);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] data;
        logic        err;
        int          nmem, lat;
        logic [1:0]  hiseq;
        bit          unstable, after_ok, timeout;
        sel = 1'b0;
        req_valid = 1'b1; req_off = 3'd0; req_size = 2'd2; req_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tests_run++;
        if (mrv32 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_req: got %0d expected 1", mrv32);
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h12345678_9ABCDEF0;
        @(negedge clk);
        mem_rvalid = 1'b0;
        tests_run++;
        if ({rr32, mrv32, mrh32, rv32, re32} !== 5'b10000 || rd32 !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_idle: got %b/%h expected 10000/00000000",
                     {rr32, mrv32, mrh32, rv32, re32}, rd32);
        end
        run_load(1'b0, 0, 2, 1'b0, 64'hCAFEBABE, 64'h0, 1'b1, 0,
                 data, err, nmem, hiseq, lat, unstable, after_ok, timeout);
        tests_run++;
        if (data !== 64'hCAFEBABE || err !== 1'b0 || lat !== 3 || timeout !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_next: got %h/%0d lat %0d expected cafebabe/0 lat 3", data, err, lat);
        end
    endtask

    task automatic test_random();
        logic [63:0] data, lo, hi, exp_data;
        logic        err, exp_err;
        int          nmem, lat, nreads, xlen, off, size, rdelay;
        logic [1:0]  hiseq;
        bit          s, uns, unstable, after_ok, timeout;
        for (int n = 0; n < 200; n++) begin
            s      = 1'($urandom_range(0, 1));
            xlen   = s ? 64 : 32;
            off    = int'($urandom_range(0, xlen/8 - 1));
            size   = int'($urandom_range(0, 3));
            uns    = 1'($urandom_range(0, 1));
            lo     = {$urandom, $urandom};
            hi     = {$urandom, $urandom};
            rdelay = int'($urandom_range(0, 4)) - 1;
            run_load(s, off, size, uns, lo, hi, 1'b0, rdelay,
                     data, err, nmem, hiseq, lat, unstable, after_ok, timeout);
            ref_load(xlen, off, size, uns, lo, hi, exp_data, exp_err, nreads);
            tests_run++;
            if (timeout !== 1'b0 || after_ok !== 1'b1 || unstable !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL random[%0d] handshake: got to=%0d after=%0d unst=%0d expected 0/1/0",
                         n, timeout, after_ok, unstable);
            end
            tests_run++;
            if (data !== exp_data || err !== exp_err) begin
                tests_failed++;
                $display("[TB] FAIL random[%0d] x%0d off%0d sz%0d u%0d: got %h/%0d expected %h/%0d",
                         n, xlen, off, size, uns, data, err, exp_data, exp_err);
            end
            tests_run++;
            if (nmem !== nreads || hiseq !== ((nreads == 2) ? 2'b10 : 2'b00)) begin
                tests_failed++;
                $display("[TB] FAIL random[%0d] mem_reqs: got %0d/%b expected %0d", n, nmem, hiseq, nreads);
            end
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst           = 1'b1;
        sel           = 1'b0;
        req_valid     = 1'b0;
        req_off       = 3'd0;
        req_size      = 2'd0;
        req_unsigned  = 1'b0;
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = 64'h0;
        resp_ready    = 1'b0;
        test_reset();
        test_directed();
        test_split();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Parametrised load-data path between the data-memory port and the writeback stage. It accepts a load request carrying byte offset, access size and signedness, and issues one memory read, or two when a load is split. It extracts the addressed bytes little-endian, sign- or zero-extends them to XLEN, and returns the result over a valid/ready handshake. It generalises the fixed 32-bit byte/half/word lane-select register to XLEN 32/64 with doubleword support, a proper request/response handshake, misalignment detection and optional split-access handling.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values 32 or 64.
- OFFW, $clog2(XLEN/8): byte-offset width; derived, do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_off  in  OFFW  byte offset within the aligned XLEN word.
- req_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword (dword legal only when XLEN=64).
- req_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- mem_req_valid  out  1  memory read request.
- mem_req_ready  in  1  memory accepts the read.
- mem_req_hi  out  1  0 = word containing the base address; 1 = next aligned word.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read data.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  XLEN  extended load result.
- resp_err  out  1  misaligned or illegal-size access.

## Operation
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: req_ready=1. A request is accepted on req_valid & req_ready, and off, size and unsigned are captured.
- Byte count is nb = 1<<size. The access is misaligned when off mod nb != 0, and crosses a word when off+nb > XLEN/8.
- An illegal size (3 with XLEN=32) goes to RESP with resp_err=1 and data 0. No memory request is issued.
- Otherwise the FSM goes to REQ0.
- REQ0: mem_req_valid=1, mem_req_hi=0, held until mem_req_ready, then WAIT0.
- WAIT0: waits for mem_rvalid and captures lo=mem_rdata. The next state is REQ1 for a split access, otherwise RESP.
- REQ1/WAIT1: same as REQ0/WAIT0 with mem_req_hi=1; captures hi, then RESP.
- Extraction: take {hi,lo} (hi=0 if unused), shift right by off*8, and keep the low nb*8 bits. Bit nb*8-1 is replicated upward unless req_unsigned; a dword (or word at XLEN=32) passes through unchanged.
- RESP: resp_valid, resp_data and resp_err are held stable until resp_ready, then the FSM returns to IDLE.
- mem_rvalid outside WAIT0/WAIT1 is ignored, including after a reset.
- At most one load is in flight; there is no request queueing.

## Timing
- Reset values: req_ready=0 during reset (1 in the first cycle after), mem_req_valid=0, mem_req_hi=0, resp_valid=0, resp_data=0, resp_err=0. The FSM is in IDLE.
- Request accepted in cycle 0 → mem_req_valid in cycle 1.
- mem_rvalid in cycle k of the final WAIT → resp_valid in cycle k+1, with data registered (no combinational rdata→resp path).
- Minimum latency is 3 cycles accept-to-resp_valid for a single access and 5 for a split access, with zero-wait memory.
- Error responses: resp_valid in cycle 1.
- Reset mid-operation forces IDLE next cycle, clears all outputs and drops any outstanding memory response.
- resp_ready may be high before resp_valid; completion still takes effect only in RESP.

## Configuration
- LOAD_MISALIGN_SPLIT_EN defined: misaligned accesses are serviced. Non-crossing ones use one read; word-crossing ones use two reads (REQ1/WAIT1) and are merged. resp_err is set only for an illegal size.
- LOAD_MISALIGN_SPLIT_EN undefined: any misaligned access goes straight to RESP with resp_err=1, data 0 and no memory request. The REQ1/WAIT1 states and the hi register are not compiled in.

## Structure
- Package load_pkg holds:
  - size encoding constants SZ_B, SZ_H, SZ_W, SZ_D;
  - the state enum;
  - the XLEN legality check.
- Sub-module load_extract (combinational): inputs {hi,lo}, off, size and unsigned; output is the extended XLEN result. It is instantiated once, feeding the RESP data register.

## Test plan
- XLEN=32, lb off=3, rdata 0x80FF1234 → resp_data 0xFFFFFF80, err 0; the same request as lbu → 0x00000080.
- lh off=2, rdata 0x80015678 → 0xFFFF8001; lhu → 0x00008001; lw off=0, rdata 0xDEADBEEF → 0xDEADBEEF.
- lw off=0 with resp_ready low for 3 cycles → resp_valid and data held constant; completes on the first cycle resp_ready is high; req_ready rises the next cycle.
- lw off=1, lo 0x44332211, hi 0x88776655:
  - with the macro → two mem requests (hi=0 then hi=1), resp 0x55443322, err 0;
  - without the macro → no mem_req_valid, err 1, data 0 in cycle 1.
- XLEN=64, ld off=0, rdata 0x8000000000000001 → same value; lw off=4 → 0xFFFFFFFF80000000; size 3 at XLEN=32 → err 1.
- Reset asserted in WAIT0, then a stray mem_rvalid arrives in IDLE → ignored; all outputs are 0 and the next request completes normally.
